// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the game sequencer: phase encoding,
// the USB keycodes it reacts to, and the boss-level rule.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_LOGO,
        ST_PLAY,
        ST_PAUSE,
        ST_DYING,
        ST_GAMEOVER,
        ST_WIN
    } game_state_t;

    localparam logic [7:0] KEY_START = 8'h28;  // Enter
    localparam logic [7:0] KEY_PAUSE = 8'h13;  // P

    // A level is a boss level when it is a multiple of the boss spacing.
    function automatic logic is_boss(input int level, input int every);
        return (every > 0) && ((level % every) == 0);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Keyboard/game-event inputs and phase/level/lives outputs of the game
// sequencer. The slave side is the sequencer; the master side drives events.
interface game_sequencer_if #(
    parameter int NUM_LEVELS = 4,
    parameter int LIVES      = 3
);
    localparam int LEVEL_W = $clog2(NUM_LEVELS + 1);
    localparam int LIVES_W = $clog2(LIVES + 1);

    logic               frame_tick;
    logic [7:0]         keycode;
    logic               died;
    logic               wave_cleared;

    logic               start;
    logic               play;
    logic               boss_logo;
    logic               paused;
    logic               gameover;
    logic               win;
    logic               boss_fight;
    logic [LEVEL_W-1:0] level;
    logic [LIVES_W-1:0] lives;
    logic               respawn;

    modport master (
        output frame_tick, keycode, died, wave_cleared,
        input  start, play, boss_logo, paused, gameover, win,
               boss_fight, level, lives, respawn
    );

    modport slave (
        input  frame_tick, keycode, died, wave_cleared,
        output start, play, boss_logo, paused, gameover, win,
               boss_fight, level, lives, respawn
    );
endinterface

// File: rtl/game_sequencer_frame_timer.sv
// Loadable frame down-counter. A load of N expires on the (N+1)th tick
// after the load cycle: done = (count == 0) && frame_tick.
module frame_timer #(
    parameter int WIDTH = 7
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             frame_tick,
    output logic             done
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over counting; count saturates at zero.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (frame_tick && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments keep register updates order-independent.
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = frame_tick && (count_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// Top-level game phase controller: attract screen, multi-level play with
// lives, boss logo, death delay, game over and win.
// Optional feature macro: GAME_PAUSE_EN compiles in the PAUSE state and
// Pause-key handling; without it 'paused' is tied low and P is ignored.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS   = 4,
    parameter int LIVES        = 3,
    parameter int BOSS_EVERY   = 2,
    parameter int LOGO_FRAMES  = 120,
    parameter int DEATH_FRAMES = 60
) (
    input  logic            Clk,
    input  logic            Reset_n,
    game_sequencer_if.slave bus
);
    localparam int LEVEL_W    = $clog2(NUM_LEVELS + 1);
    localparam int LIVES_W    = $clog2(LIVES + 1);
    localparam int MAX_FRAMES = (LOGO_FRAMES > DEATH_FRAMES) ? LOGO_FRAMES : DEATH_FRAMES;
    localparam int TIMER_W    = $clog2(MAX_FRAMES + 1);

    localparam logic [TIMER_W-1:0] LOGO_LOAD  = TIMER_W'(LOGO_FRAMES);
    localparam logic [TIMER_W-1:0] DEATH_LOAD = TIMER_W'(DEATH_FRAMES);

    game_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [7:0]         key_q;
    logic               respawn_q, respawn_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_tick;
    logic               timer_done;
    logic               start_ev;

    // Key events fire once per press: current code differs from last cycle's.
    assign start_ev   = (bus.keycode == KEY_START) && (key_q != KEY_START);
`ifdef GAME_PAUSE_EN
    logic pause_ev;
    assign pause_ev   = (bus.keycode == KEY_PAUSE) && (key_q != KEY_PAUSE);
`endif

    // The timer only advances in the two timed phases, so PAUSE freezes nothing.
    assign timer_tick = bus.frame_tick && ((state_q == ST_LOGO) || (state_q == ST_DYING));

    frame_timer #(.WIDTH(TIMER_W)) u_timer (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (timer_load),
        .value      (timer_value),
        .frame_tick (timer_tick),
        .done       (timer_done)
    );

    // Phase transitions, level/lives bookkeeping and timer loads.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        lives_d     = lives_q;
        respawn_d   = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            ST_START: begin
                if (start_ev) begin
                    level_d = LEVEL_W'(1);
                    lives_d = LIVES_W'(LIVES);
                    if (is_boss(1, BOSS_EVERY)) begin
                        timer_load  = 1'b1;
                        timer_value = LOGO_LOAD;
                        state_d     = ST_LOGO;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_LOGO: begin
                if (timer_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.died) begin
                    lives_d     = lives_q - LIVES_W'(1);
                    timer_load  = 1'b1;
                    timer_value = DEATH_LOAD;
                    state_d     = ST_DYING;
                end else if (bus.wave_cleared) begin
                    if (level_q == LEVEL_W'(NUM_LEVELS)) begin
                        state_d = ST_WIN;
                    end else begin
                        level_d = level_q + LEVEL_W'(1);
                        if (is_boss(int'(level_q) + 1, BOSS_EVERY)) begin
                            timer_load  = 1'b1;
                            timer_value = LOGO_LOAD;
                            state_d     = ST_LOGO;
                        end
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (pause_ev) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (pause_ev) state_d = ST_PLAY;
            end
`endif
            ST_DYING: begin
                if (timer_done) begin
                    if (lives_q == '0) begin
                        state_d = ST_GAMEOVER;
                    end else begin
                        respawn_d = 1'b1;
                        state_d   = ST_PLAY;
                    end
                end
            end
            ST_GAMEOVER, ST_WIN: begin
                if (start_ev) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
    end

    // State, bookkeeping and key-history registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= ST_START;
            level_q   <= LEVEL_W'(1);
            lives_q   <= LIVES_W'(LIVES);
            key_q     <= '0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            key_q     <= bus.keycode;
            respawn_q <= respawn_d;
        end
    end

    assign bus.start      = (state_q == ST_START);
    assign bus.play       = (state_q == ST_PLAY) || (state_q == ST_DYING);
    assign bus.boss_logo  = (state_q == ST_LOGO);
`ifdef GAME_PAUSE_EN
    assign bus.paused     = (state_q == ST_PAUSE);
`else
    assign bus.paused     = 1'b0;
`endif
    assign bus.gameover   = (state_q == ST_GAMEOVER);
    assign bus.win        = (state_q == ST_WIN);
    assign bus.boss_fight = is_boss(int'(level_q), BOSS_EVERY) &&
                            ((state_q == ST_PLAY) || (state_q == ST_PAUSE) || (state_q == ST_DYING));
    assign bus.level      = level_q;
    assign bus.lives      = lives_q;
    assign bus.respawn    = respawn_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer (NUM_LEVELS=4, LIVES=3, BOSS_EVERY=2,
// LOGO_FRAMES=120, DEATH_FRAMES=60). Handles builds with or without GAME_PAUSE_EN.
module tb_game_sequencer;

    // Flag vector order: {start, play, boss_logo, paused, gameover, win}
    localparam logic [5:0] F_START = 6'b100000;
    localparam logic [5:0] F_PLAY  = 6'b010000;
    localparam logic [5:0] F_LOGO  = 6'b001000;
    localparam logic [5:0] F_PAUSE = 6'b000100;
    localparam logic [5:0] F_OVER  = 6'b000010;
    localparam logic [5:0] F_WIN   = 6'b000001;

    typedef struct {
        logic [7:0] key;
        logic       died;
        logic       clr;
        logic       tick;
        logic [5:0] flags;
        int         level;
        int         lives;
        logic       boss;
        logic       resp;
        string      name;
    } vec_t;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t vq[$];

    always #5 Clk = ~Clk;

    game_sequencer_if #(.NUM_LEVELS(4), .LIVES(3)) bus ();

    game_sequencer #(
        .NUM_LEVELS   (4),
        .LIVES        (3),
        .BOSS_EVERY   (2),
        .LOGO_FRAMES  (120),
        .DEATH_FRAMES (60)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {bus.start, bus.play, bus.boss_logo, bus.paused, bus.gameover, bus.win};
    endfunction

    task automatic check_all(input string name, input logic [5:0] f, input int lvl,
                             input int lv, input logic boss, input logic resp);
        check({name, " flags"},   32'(flags()),          32'(f));
        check({name, " level"},   32'(bus.level),        32'(lvl));
        check({name, " lives"},   32'(bus.lives),        32'(lv));
        check({name, " boss"},    32'(bus.boss_fight),   32'(boss));
        check({name, " respawn"}, 32'(bus.respawn),      32'(resp));
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
        end
        bus.frame_tick = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        bus.keycode = k;
        step();
        bus.keycode = 8'h00;
    endtask

    task automatic pulse_died();
        bus.died = 1'b1;
        step();
        bus.died = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.wave_cleared = 1'b1;
        step();
        bus.wave_cleared = 1'b0;
    endtask

    // Time bound: the directed run needs only a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_tick   = 1'b0;
        bus.keycode      = 8'h00;
        bus.died         = 1'b0;
        bus.wave_cleared = 1'b0;

        // Reset state
        step();
        check_all("reset", F_START, 1, 3, 1'b0, 1'b0);
        Reset_n = 1'b1;

        // Vector table: one cycle each, from START after reset.
        vq.push_back('{8'h00, 1'b0, 1'b0, 1'b0, F_START, 1, 3, 1'b0, 1'b0, "idle"});
        vq.push_back('{8'h00, 1'b1, 1'b1, 1'b1, F_START, 1, 3, 1'b0, 1'b0, "events_in_start"});
        vq.push_back('{8'h13, 1'b0, 1'b0, 1'b0, F_START, 1, 3, 1'b0, 1'b0, "pause_in_start"});
        vq.push_back('{8'h28, 1'b0, 1'b0, 1'b0, F_PLAY,  1, 3, 1'b0, 1'b0, "start_key"});
        for (int i = 0; i < 10; i++)
            vq.push_back('{8'h28, 1'b0, 1'b0, 1'b0, F_PLAY, 1, 3, 1'b0, 1'b0, "start_held"});
        vq.push_back('{8'h00, 1'b0, 1'b0, 1'b1, F_PLAY,  1, 3, 1'b0, 1'b0, "tick_in_play"});
        vq.push_back('{8'h28, 1'b0, 1'b0, 1'b0, F_PLAY,  1, 3, 1'b0, 1'b0, "start_in_play"});
        vq.push_back('{8'h00, 1'b0, 1'b1, 1'b0, F_LOGO,  2, 3, 1'b0, 1'b0, "clear_to_logo"});
        vq.push_back('{8'h00, 1'b1, 1'b0, 1'b0, F_LOGO,  2, 3, 1'b0, 1'b0, "died_in_logo"});
        vq.push_back('{8'h28, 1'b0, 1'b1, 1'b0, F_LOGO,  2, 3, 1'b0, 1'b0, "keys_in_logo"});
        vq.push_back('{8'h00, 1'b0, 1'b0, 1'b0, F_LOGO,  2, 3, 1'b0, 1'b0, "logo_idle"});

        for (int i = 0; i < vq.size(); i++) begin
            bus.keycode      = vq[i].key;
            bus.died         = vq[i].died;
            bus.wave_cleared = vq[i].clr;
            bus.frame_tick   = vq[i].tick;
            step();
            check_all($sformatf("vec%0d_%s", i, vq[i].name), vq[i].flags, vq[i].level,
                      vq[i].lives, vq[i].boss, vq[i].resp);
        end
        bus.keycode      = 8'h00;
        bus.died         = 1'b0;
        bus.wave_cleared = 1'b0;
        bus.frame_tick   = 1'b0;

        // Boss logo: loaded with 120, expires on the 121st tick; holds without ticks.
        ticks(120);
        check_all("logo_120_ticks", F_LOGO, 2, 3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check_all("logo_no_tick_hold", F_LOGO, 2, 3, 1'b0, 1'b0);
        ticks(1);
        check_all("logo_done", F_PLAY, 2, 3, 1'b1, 1'b0);

        // Three deaths at level 2.
        for (int d = 1; d <= 3; d++) begin
            pulse_died();
            check_all($sformatf("death%0d", d), F_PLAY, 2, 3 - d, 1'b1, 1'b0);
            if (d == 1) begin
                pulse_clr();
                pulse_died();
                check_all("events_in_dying", F_PLAY, 2, 2, 1'b1, 1'b0);
            end
            ticks(60);
            check_all($sformatf("death%0d_60", d), F_PLAY, 2, 3 - d, 1'b1, 1'b0);
            ticks(1);
            if (d < 3) begin
                check_all($sformatf("death%0d_respawn", d), F_PLAY, 2, 3 - d, 1'b1, 1'b1);
                step();
                check_all($sformatf("death%0d_after", d), F_PLAY, 2, 3 - d, 1'b1, 1'b0);
            end else begin
                check_all("gameover", F_OVER, 2, 0, 1'b0, 1'b0);
            end
        end
        press(8'h28);
        check_all("over_to_start", F_START, 2, 0, 1'b0, 1'b0);
        step();

        // New game: died and wave_cleared together, died wins.
        press(8'h28);
        check_all("game2_start", F_PLAY, 1, 3, 1'b0, 1'b0);
        bus.died         = 1'b1;
        bus.wave_cleared = 1'b1;
        step();
        bus.died         = 1'b0;
        bus.wave_cleared = 1'b0;
        check_all("died_and_clear", F_PLAY, 1, 2, 1'b0, 1'b0);
        ticks(61);
        check_all("game2_respawn", F_PLAY, 1, 2, 1'b0, 1'b1);

        // Clear all four waves.
        pulse_clr();
        check_all("clear1", F_LOGO, 2, 2, 1'b0, 1'b0);
        ticks(121);
        check_all("clear1_logo_done", F_PLAY, 2, 2, 1'b1, 1'b0);
        pulse_clr();
        check_all("clear2", F_PLAY, 3, 2, 1'b0, 1'b0);
        pulse_clr();
        check_all("clear3", F_LOGO, 4, 2, 1'b0, 1'b0);
        ticks(121);
        check_all("clear3_logo_done", F_PLAY, 4, 2, 1'b1, 1'b0);
        pulse_clr();
        check_all("clear4_win", F_WIN, 4, 2, 1'b0, 1'b0);
        pulse_clr();
        check_all("clear_in_win", F_WIN, 4, 2, 1'b0, 1'b0);
        press(8'h28);
        check_all("win_to_start", F_START, 4, 2, 1'b0, 1'b0);
        step();

        // Pause handling.
        press(8'h28);
        check_all("game3_start", F_PLAY, 1, 3, 1'b0, 1'b0);
        step();
        press(8'h13);
`ifdef GAME_PAUSE_EN
        check_all("pause_on", F_PAUSE, 1, 3, 1'b0, 1'b0);
        step();
        pulse_died();
        ticks(50);
        pulse_clr();
        press(8'h28);
        check_all("pause_ignores", F_PAUSE, 1, 3, 1'b0, 1'b0);
        step();
        press(8'h13);
        check_all("pause_off", F_PLAY, 1, 3, 1'b0, 1'b0);
`else
        check_all("pause_key_ignored", F_PLAY, 1, 3, 1'b0, 1'b0);
`endif
        step();

        // Reset in the middle of a boss logo.
        pulse_clr();
        check_all("logo_again", F_LOGO, 2, 3, 1'b0, 1'b0);
        ticks(30);
        Reset_n = 1'b0;
        step();
        check_all("reset_mid_logo", F_START, 1, 3, 1'b0, 1'b0);
        Reset_n = 1'b1;
        step();
        check_all("after_reset", F_START, 1, 3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Parametrised top-level game state controller for the Galaga design: it succeeds the fixed single-level controller. It sequences the attract screen, multi-level play with a life counter, boss-level intro logo, pause, game over and win. It sits between the keyboard keycode path and the sprite and render logic, which consume its one-hot phase flags, level and lives. All state changes are synchronous to `Clk`, and all timed phases count `frame_tick` pulses.

## Interface
- `NUM_LEVELS`, default 4: number of waves; clearing the last wave wins.
- `LIVES`, default 3: lives at game start, must be at least 1.
- `BOSS_EVERY`, default 2: a level is a boss level when `level % BOSS_EVERY == 0`.
- `LOGO_FRAMES`, default 120: frames that the boss logo is shown.
- `DEATH_FRAMES`, default 60: frames of the death/respawn delay.
- `Clk`, input, 1 bit: system clock.
- `Reset_n`, input, 1 bit: reset, synchronous, active-low.
- `frame_tick`, input, 1 bit: one-cycle pulse per vsync.
- `keycode`, input, 8 bits: current USB keycode; 0 when no key is pressed.
- `died`, input, 1 bit: one-cycle pulse when the player ship is hit.
- `wave_cleared`, input, 1 bit: one-cycle pulse when all enemies of the current wave are dead.
- `start`, `play`, `boss_logo`, `paused`, `gameover`, `win`, outputs, 1 bit each: phase flags, exactly one high at all times.
- `boss_fight`, output, 1 bit: the current level is a boss level; valid in PLAY, PAUSE and DYING.
- `level`, output, $clog2(NUM_LEVELS+1) bits: current level, 1-based.
- `lives`, output, $clog2(LIVES+1) bits: remaining lives.
- `respawn`, output, 1 bit: one-cycle pulse when the ship re-enters play after a death.

## Operation
- States are START, LOGO, PLAY, PAUSE, DYING, GAMEOVER and WIN. Each phase flag decodes its own state; DYING also drives `play`=1.
- Key events are edge-detected against a registered copy of `keycode`. An event is `keycode==K && key_q!=K`, so a held key fires once. The Start key is 8'h28 (Enter); the Pause key is 8'h13 (P).
- START + Start key:
  - Set `level`=1 and `lives`=LIVES.
  - Go to LOGO if level 1 is a boss level, otherwise to PLAY.
- PLAY + `died`:
  - Decrement `lives`.
  - Load the timer with DEATH_FRAMES and go to DYING.
- PLAY + `wave_cleared` (with no `died` that cycle):
  - If `level==NUM_LEVELS`, go to WIN.
  - Otherwise increment `level`. If the new level is a boss level, load the timer with LOGO_FRAMES and go to LOGO; otherwise stay in PLAY.
- PLAY + `died` and `wave_cleared` in the same cycle: `died` wins and the clear is dropped.
- DYING, timer done:
  - If `lives==0`, go to GAMEOVER.
  - Otherwise pulse `respawn` and go to PLAY.
  - `died` and `wave_cleared` are ignored while in DYING.
- LOGO, timer done: go to PLAY with `boss_fight`=1.
- PLAY + Pause key: go to PAUSE. PAUSE + Pause key: go back to PLAY.
  - In PAUSE, `died`, `wave_cleared` and `frame_tick` are ignored.
  - The Start key is ignored in PLAY and PAUSE.
- GAMEOVER or WIN + Start key: go to START. `level` and `lives` hold until the next game starts.
- Arithmetic:
  - `lives` never underflows; `died` is only accepted in PLAY, where `lives` is at least 1.
  - `level` never exceeds NUM_LEVELS.
- Timer: decrements only on `frame_tick`. Done means the count equals 0 and `frame_tick` is high. A load value of N therefore gives N+1 ticks, with the first tick consumed in the load cycle excluded.

## Timing
- Reset values: `start`=1, all other flags 0, `boss_fight`=0, `level`=1, `lives`=LIVES, `respawn`=0, `key_q`=0, timer=0.
- All outputs are registered. An input event at clock edge *n* is reflected on the outputs after edge *n*, i.e. 1-cycle latency.
- `respawn` is high for exactly the first cycle in PLAY after DYING.
- `Reset_n` low in any state, including mid-timer, returns to START on the next edge; the timer is cleared.
- With `frame_tick` held low, LOGO and DYING hold indefinitely.

## Configuration
- `GAME_PAUSE_EN` defined: the PAUSE state and Pause-key handling are compiled in.
- Not defined:
  - PAUSE is absent and the 8'h13 keycode is ignored.
  - `paused` is tied to 0.
  - The port list is unchanged.

## Structure
- Package `game_pkg` holds:
  - the state enum `game_state_t`;
  - key constants `KEY_START`=8'h28 and `KEY_PAUSE`=8'h13;
  - the function `is_boss(level, every)`.
- One sub-module, `frame_timer`:
  - loadable down-counter of $clog2(max(LOGO_FRAMES, DEATH_FRAMES)+1) bits;
  - inputs `load`, `value` and `frame_tick`; output `done`.

## Test plan
- Reset, then keycode 8'h28 for 1 cycle → `play`=1, `level`=1, `lives`=3, `boss_fight`=0. Holding 8'h28 for 10 more cycles causes no further transition.
- In PLAY, `wave_cleared` pulse → `boss_logo`=1 and `level`=2. After 121 `frame_tick` pulses → `play`=1 and `boss_fight`=1.
- `died` three times, each followed by 61 ticks:
  - `respawn` pulses after the first and second deaths;
  - `lives` reads 2, 1, 0;
  - after the third delay the state is `gameover`=1;
  - 8'h28 then returns to `start`=1.
- `died` and `wave_cleared` in the same cycle at level 1 → DYING, `level` stays 1, `lives`=2.
- Clear 4 waves (NUM_LEVELS=4) → `win`=1 after the 4th clear.
- With `GAME_PAUSE_EN` defined: 8'h13 in PLAY → `paused`=1. `died` and 50 ticks during the pause have no effect. 8'h13 again → `play`=1 with `lives` unchanged.
- `Reset_n`=0 mid-LOGO → `start`=1, `level`=1 on the next edge.
